mfp_uart_transmitter: RTL and testbench

- Serial UART transmitter: byte writes are buffered in a small FIFO and sent on `UART_TX` as 8N1 frames (8E1 when parity is enabled), LSB first.
- Counterpart of the UART receiver that feeds the memory loader.
- Instantiated inside `mfp_system` behind a memory-mapped register, so firmware can print to the same serial cable used for program download.

---
 rtl/mfp_uart_pkg.sv | 37 +++
 rtl/mfp_uart_tx_fifo.sv | 71 +++++++
 rtl/mfp_uart_transmitter.sv | 184 ++++++++++++++++++
 tb/tb_mfp_uart_transmitter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mfp_uart_pkg.sv
// ---------------------------------------------------------------------------
// mfp_uart_pkg
// Shared definitions for the MFP UART transmitter and receiver:
//   - tx_state_e       : transmitter FSM state encodings
//   - clks_per_bit()   : baud divider, CLOCK_FREQUENCY / BAUD_RATE (truncating)
//   - FRAME_BITS_*     : line bits per frame (8N1 = 10, 8E1 = 11)
// Optional feature macro: MFP_UART_TX_PARITY_EN (adds the PARITY state and
// selects the 11-bit frame length).
// ---------------------------------------------------------------------------
package mfp_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef MFP_UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  localparam int FRAME_BITS_8N1 = 10;
  localparam int FRAME_BITS_8E1 = 11;

`ifdef MFP_UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
  localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

  // Integer truncation is intentional: the receiver uses the same divider,
  // so both ends drift identically relative to the nominal baud rate.
  function automatic int clks_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/mfp_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// mfp_uart_tx_fifo
// Synchronous byte FIFO with 2^DEPTH_LOG2 entries, first-word fall-through
// (rd_data always shows the head entry).
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   wr_en     - enqueue wr_data (ignored while full)
//   wr_data   - byte to enqueue
//   rd_en     - pop the head entry (ignored while empty)
//   rd_data   - head entry
//   full      - registered, FIFO holds 2^DEPTH_LOG2 bytes
//   empty     - registered, FIFO holds no bytes
// ---------------------------------------------------------------------------
module mfp_uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);

  localparam int PTR_W = DEPTH_LOG2 + 1;

  // The extra MSB distinguishes full (MSBs differ) from empty (MSBs equal)
  // when the low address bits coincide.
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W-1:0] wr_ptr_n, rd_ptr_n;
  logic [7:0]       mem [2**DEPTH_LOG2];
  logic             wr_fire, rd_fire;

  // Both strobes are qualified with the current flags, so a write on a full
  // FIFO is dropped even in a cycle where the head is also popped.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wr_ptr_n = wr_fire ? wr_ptr + PTR_W'(1) : wr_ptr;
    rd_ptr_n = rd_fire ? rd_ptr + PTR_W'(1) : rd_ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= (wr_ptr_n[PTR_W-1] != rd_ptr_n[PTR_W-1]) &&
                (wr_ptr_n[PTR_W-2:0] == rd_ptr_n[PTR_W-2:0]);
      empty  <= (wr_ptr_n == rd_ptr_n);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr[PTR_W-2:0]] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr[PTR_W-2:0]];

endmodule

// File: rtl/mfp_uart_transmitter.sv
// ---------------------------------------------------------------------------
// mfp_uart_transmitter
// Buffered UART transmitter: bytes written through write_en/write_data are
// queued in a FIFO and sent LSB first as 8N1 frames (8E1 with even parity
// when MFP_UART_TX_PARITY_EN is defined).
// Ports:
//   SI_ClkIn   - clock, rising edge
//   SI_Reset   - asynchronous active-high reset
//   write_en   - write strobe, one byte per cycle
//   write_data - byte to enqueue
//   full       - FIFO full, writes dropped while high
//   empty      - FIFO empty
//   busy       - a frame is on the line
//   overflow   - sticky, a write arrived while full (cleared by reset only)
//   UART_TX    - registered serial line, idle high
// Optional feature macro: MFP_UART_TX_PARITY_EN.
// ---------------------------------------------------------------------------
module mfp_uart_transmitter
  import mfp_uart_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 50000000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       SI_ClkIn,
  input  logic       SI_Reset,
  input  logic       write_en,
  input  logic [7:0] write_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       overflow,
  output logic       UART_TX
);

  localparam int                CLKS_PER_BIT = clks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int                CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e        state, state_n;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shift_q, shift_n;
  logic             tx_q, tx_n;
  logic             busy_q, overflow_q;
  logic             pop, bit_done;
  logic [7:0]       fifo_rd_data;
`ifdef MFP_UART_TX_PARITY_EN
  logic             parity_q;
`endif

  mfp_uart_tx_fifo #(
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk     (SI_ClkIn),
    .rst     (SI_Reset),
    .wr_en   (write_en),
    .wr_data (write_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (full),
    .empty   (empty)
  );

  assign bit_done = (bit_cnt == CNT_LAST);

  // tx_n is the value the line takes after this edge, so UART_TX comes
  // straight from a flop and changes exactly on bit boundaries.
  // NOTE: every output is given a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift_q;
    tx_n      = tx_q;
    pop       = 1'b0;

    if (state != IDLE) begin
      bit_cnt_n = bit_done ? '0 : bit_cnt + CNT_W'(1);
    end

    unique case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = fifo_rd_data;
          state_n = START;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          bit_idx_n = 3'd0;
          tx_n      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'd7) begin
`ifdef MFP_UART_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift_q[7:1]};
            tx_n      = shift_q[1];
          end
        end
      end
`ifdef MFP_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_done) begin
          // Chaining straight into START keeps back-to-back frames gapless.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = fifo_rd_data;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      bit_idx    <= bit_idx_n;
      shift_q    <= shift_n;
      tx_q       <= tx_n;
      busy_q     <= (state_n != IDLE);
      overflow_q <= overflow_q || (write_en && full);
    end
  end

`ifdef MFP_UART_TX_PARITY_EN
  // The shift register is consumed during DATA, so parity is captured from
  // the byte as it is popped.
  always_ff @(posedge SI_ClkIn or posedge SI_Reset) begin
    if (SI_Reset) begin
      parity_q <= 1'b0;
    end else if (pop) begin
      parity_q <= ^fifo_rd_data;
    end
  end
`endif

  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign UART_TX  = tx_q;

endmodule

// File: tb/tb_mfp_uart_transmitter.sv
// ---------------------------------------------------------------------------
// tb_mfp_uart_transmitter
// Directed self-checking bench for mfp_uart_transmitter with
// CLOCK_FREQUENCY=1000, BAUD_RATE=100 (10 clocks per bit), FIFO depth 4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_mfp_uart_transmitter;

  localparam int CPB = 10;
`ifdef MFP_UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int LAST = FB * CPB - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic [7:0] write_data;
  logic       full, empty, busy, overflow, uart_tx;

  int checks   = 0;
  int failures = 0;

  mfp_uart_transmitter #(
    .CLOCK_FREQUENCY (1000),
    .BAUD_RATE       (100),
    .FIFO_DEPTH_LOG2 (2)
  ) dut (
    .SI_ClkIn   (clk),
    .SI_Reset   (rst),
    .write_en   (write_en),
    .write_data (write_data),
    .full       (full),
    .empty      (empty),
    .busy       (busy),
    .overflow   (overflow),
    .UART_TX    (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line bit i of a frame carrying b: start, 8 data bits LSB first,
  // optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (FB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  // Cycle k counts from the edge that popped b; entry must be at cycle first.
  task automatic check_frame(input logic [7:0] b, input int first, input int last);
    for (int k = first; k <= last; k++) begin
      check($sformatf("tx_%02h_k%0d", b, k), uart_tx, frame_bit(b, k / CPB));
      check($sformatf("busy_%02h_k%0d", b, k), busy, 1'b1);
      tick();
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_tx"}, uart_tx, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_empty"}, empty, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    write_en   = 1'b0;
    write_data = 8'h00;

    // Reset state
    #1;
    check("rst_tx", uart_tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_full", full, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_overflow", overflow, 1'b0);
    #12;
    rst = 1'b0;
    tick();
    check_idle("post_rst");

    // Single byte 0xA5
    write_en = 1'b1; write_data = 8'hA5;
    tick();
    write_en = 1'b0;
    check("a5_empty_after_write", empty, 1'b0);
    check("a5_busy_before_pop", busy, 1'b0);
    check("a5_tx_before_pop", uart_tx, 1'b1);
    tick();
    check("a5_empty_after_pop", empty, 1'b1);
    check_frame(8'hA5, 0, LAST);
    check_idle("a5_done");

    // Back-to-back 0x00, 0xFF
    write_en = 1'b1; write_data = 8'h00;
    tick();
    write_data = 8'hFF;
    tick();
    write_en = 1'b0;
    check("b2b_empty_pending", empty, 1'b0);
    check_frame(8'h00, 0, LAST);
    check_frame(8'hFF, 0, LAST);
    check_idle("b2b_done");

    // Fill and overflow: 0x10 popped at once, 0x11..0x14 fill, 0x15 dropped
    for (int i = 0; i < 6; i++) begin
      write_en   = 1'b1;
      write_data = 8'h10 + 8'(i);
      tick();
      if (i == 3) check("fill_not_full_3", full, 1'b0);
      if (i == 4) begin
        check("fill_full_4", full, 1'b1);
        check("fill_no_ovf_4", overflow, 1'b0);
      end
      if (i == 5) begin
        check("fill_full_5", full, 1'b1);
        check("fill_ovf_5", overflow, 1'b1);
      end
    end
    write_en = 1'b0;
    check_frame(8'h10, 4, LAST);
    check("fill_full_after_pop", full, 1'b0);
    for (int i = 1; i < 5; i++) begin
      check_frame(8'h10 + 8'(i), 0, LAST);
    end
    check_idle("fill_done");
    check("fill_ovf_sticky", overflow, 1'b1);

    // Write while full in the pop cycle: 0x77 dropped, occupancy 4 -> 3
    rst = 1'b1;
    tick();
    check("rst2_ovf_clear", overflow, 1'b0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      write_en   = 1'b1;
      write_data = 8'hA0 + 8'(i);
      tick();
    end
    write_en = 1'b0;
    check("popw_full", full, 1'b1);
    check("popw_no_ovf", overflow, 1'b0);
    check_frame(8'hA0, 3, LAST - 1);
    write_en = 1'b1; write_data = 8'h77;
    tick();
    write_en = 1'b0;
    check("popw_ovf", overflow, 1'b1);
    check("popw_full_after", full, 1'b0);
    check("popw_empty_after", empty, 1'b0);
    for (int i = 1; i < 5; i++) begin
      check_frame(8'hA0 + 8'(i), 0, LAST);
    end
    check_idle("popw_done");

    // Reset during data bit 3 of 0x3C with 0x81 still queued
    write_en = 1'b1; write_data = 8'h3C;
    tick();
    write_data = 8'h81;
    tick();
    write_en = 1'b0;
    check_frame(8'h3C, 0, 4 * CPB + 3);
    rst = 1'b1;
    #2;
    check("midrst_tx", uart_tx, 1'b1);
    check("midrst_empty", empty, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_full", full, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check_idle("midrst_flushed");
    write_en = 1'b1; write_data = 8'h55;
    tick();
    write_en = 1'b0;
    tick();
    check_frame(8'h55, 0, LAST);
    check_idle("midrst_55_done");

`ifdef MFP_UART_TX_PARITY_EN
    // Even parity: 0x07 -> 1, 0x03 -> 0
    write_en = 1'b1; write_data = 8'h07;
    tick();
    write_en = 1'b0;
    tick();
    check_frame(8'h07, 0, 9 * CPB - 1);
    check("par07_bit", uart_tx, 1'b1);
    check_frame(8'h07, 9 * CPB, LAST);
    check_idle("par07_done");
    write_en = 1'b1; write_data = 8'h03;
    tick();
    write_en = 1'b0;
    tick();
    check_frame(8'h03, 0, 9 * CPB - 1);
    check("par03_bit", uart_tx, 1'b0);
    check_frame(8'h03, 9 * CPB, LAST);
    check_idle("par03_done");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
